// File: rtl/quiz_pkg.sv
// Shared encodings and default limits for the quiz setup controller and game core.
package quiz_pkg;

  localparam int QZ_VAL_W       = 6;
  localparam int QZ_MIN_PLAYERS = 2;
  localparam int QZ_MAX_PLAYERS = 4;
  localparam int QZ_MAX_SECONDS = 60;
  localparam int QZ_MAX_POINTS  = 63;
  localparam int QZ_DEF_SECONDS = 20;
  localparam int QZ_DEF_POINTS  = 1;

  // Field indices double as the state encoding so cur_field is the state register itself.
  localparam logic [2:0] FLD_IDLE    = 3'd0;
  localparam logic [2:0] FLD_PEOPLE  = 3'd1;
  localparam logic [2:0] FLD_SECS    = 3'd2;
  localparam logic [2:0] FLD_CORR    = 3'd3;
  localparam logic [2:0] FLD_MISS    = 3'd4;
  localparam logic [2:0] FLD_CONFIRM = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = FLD_IDLE,
    S_PEOPLE  = FLD_PEOPLE,
    S_SECS    = FLD_SECS,
    S_CORR    = FLD_CORR,
    S_MISS    = FLD_MISS,
    S_CONFIRM = FLD_CONFIRM
  } state_t;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector: one history flop and an AND gate.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic rise
);

  logic lvl_q;

  always_ff @(posedge clk) begin
    if (rst) lvl_q <= 1'b0;
    else     lvl_q <= lvl;
  end

  assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/quiz_setup_ctrl.sv
// Setup sequencer: range-checked entry into shadow registers, atomic commit on confirm.
//   state     | meaning
//   IDLE      | committed config in use, waiting for setting_en rising edge
//   S_PEOPLE  | entering player count
//   S_SECS    | entering countdown seconds
//   S_CORR    | entering correct-answer points
//   S_MISS    | entering mistake points
//   S_CONFIRM | waiting for final enter to commit
module quiz_setup_ctrl
  import quiz_pkg::*;
#(
  parameter int VAL_W       = QZ_VAL_W,
  parameter int MIN_PLAYERS = QZ_MIN_PLAYERS,
  parameter int MAX_PLAYERS = QZ_MAX_PLAYERS,
  parameter int MAX_SECONDS = QZ_MAX_SECONDS,
  parameter int MAX_POINTS  = QZ_MAX_POINTS,
  parameter int DEF_SECONDS = QZ_DEF_SECONDS,
  parameter int DEF_POINTS  = QZ_DEF_POINTS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             setting_en,
  input  logic             enter_btn,
  input  logic             back_btn,
  input  logic [VAL_W-1:0] input_val,
  output logic             is_set_over,
  output logic [VAL_W-1:0] num_people,
  output logic [VAL_W-1:0] count_seconds,
  output logic [VAL_W-1:0] correct_point,
  output logic [VAL_W-1:0] mistake_point,
  output logic [2:0]       cur_field,
  output logic             reject,
  output logic             commit
);

  // One extra bit keeps full-scale limits from making the compares trivially constant.
  localparam logic [VAL_W:0] LIM_ONE   = (VAL_W+1)'(1);
  localparam logic [VAL_W:0] LIM_MIN_P = (VAL_W+1)'(MIN_PLAYERS);
  localparam logic [VAL_W:0] LIM_MAX_P = (VAL_W+1)'(MAX_PLAYERS);
  localparam logic [VAL_W:0] LIM_MAX_S = (VAL_W+1)'(MAX_SECONDS);
  localparam logic [VAL_W:0] LIM_MAX_PT = (VAL_W+1)'(MAX_POINTS);

  state_t           state_q, state_d;
  logic [VAL_W-1:0] sh_people_q, sh_secs_q, sh_corr_q, sh_miss_q;
  logic [VAL_W-1:0] sh_people_d, sh_secs_d, sh_corr_d, sh_miss_d;
  logic [VAL_W-1:0] cfg_people_q, cfg_secs_q, cfg_corr_q, cfg_miss_q;
  logic [VAL_W-1:0] cfg_people_d, cfg_secs_d, cfg_corr_d, cfg_miss_d;
  logic             over_q, over_d, prev_over_q, prev_over_d;
  logic             reject_q, reject_d, commit_q, commit_d;
  logic             enter_e, back_e, set_e, field_ok;
  logic [VAL_W:0]   val_x;

  btn_edge u_enter (.clk(clk), .rst(rst), .lvl(enter_btn),  .rise(enter_e));
  btn_edge u_back  (.clk(clk), .rst(rst), .lvl(back_btn),   .rise(back_e));
  btn_edge u_set   (.clk(clk), .rst(rst), .lvl(setting_en), .rise(set_e));

  assign val_x = {1'b0, input_val};

  always_comb begin
    field_ok = 1'b0;
    case (state_q)
      S_PEOPLE:     field_ok = (val_x >= LIM_MIN_P) && (val_x <= LIM_MAX_P);
      S_SECS:       field_ok = (val_x >= LIM_ONE) && (val_x <= LIM_MAX_S);
      S_CORR, S_MISS: field_ok = (val_x >= LIM_ONE) && (val_x <= LIM_MAX_PT);
      default:      field_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    sh_people_d  = sh_people_q;
    sh_secs_d    = sh_secs_q;
    sh_corr_d    = sh_corr_q;
    sh_miss_d    = sh_miss_q;
    cfg_people_d = cfg_people_q;
    cfg_secs_d   = cfg_secs_q;
    cfg_corr_d   = cfg_corr_q;
    cfg_miss_d   = cfg_miss_q;
    over_d       = over_q;
    prev_over_d  = prev_over_q;
    reject_d     = 1'b0;
    commit_d     = 1'b0;

    if (state_q == IDLE) begin
      if (set_e) begin
        state_d     = S_PEOPLE;
        sh_people_d = cfg_people_q;
        sh_secs_d   = cfg_secs_q;
        sh_corr_d   = cfg_corr_q;
        sh_miss_d   = cfg_miss_q;
        prev_over_d = over_q;
        over_d      = 1'b0;
      end
    end else if (!setting_en) begin
      state_d = IDLE;
      over_d  = prev_over_q;
    end else if (enter_e) begin
      if (state_q == S_CONFIRM) begin
        cfg_people_d = sh_people_q;
        cfg_secs_d   = sh_secs_q;
        cfg_corr_d   = sh_corr_q;
        cfg_miss_d   = sh_miss_q;
        commit_d     = 1'b1;
        over_d       = 1'b1;
        state_d      = IDLE;
      end else if (!field_ok) begin
        reject_d = 1'b1;
      end else begin
        case (state_q)
          S_PEOPLE: begin sh_people_d = input_val; state_d = S_SECS;    end
          S_SECS:   begin sh_secs_d   = input_val; state_d = S_CORR;    end
          S_CORR:   begin sh_corr_d   = input_val; state_d = S_MISS;    end
          S_MISS:   begin sh_miss_d   = input_val; state_d = S_CONFIRM; end
          default:  state_d = state_q;
        endcase
      end
    end else if (back_e) begin
      case (state_q)
        S_SECS:    state_d = S_PEOPLE;
        S_CORR:    state_d = S_SECS;
        S_MISS:    state_d = S_CORR;
        S_CONFIRM: state_d = S_MISS;
        default:   state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sh_people_q  <= VAL_W'(MIN_PLAYERS);
      sh_secs_q    <= VAL_W'(DEF_SECONDS);
      sh_corr_q    <= VAL_W'(DEF_POINTS);
      sh_miss_q    <= VAL_W'(DEF_POINTS);
      cfg_people_q <= VAL_W'(MIN_PLAYERS);
      cfg_secs_q   <= VAL_W'(DEF_SECONDS);
      cfg_corr_q   <= VAL_W'(DEF_POINTS);
      cfg_miss_q   <= VAL_W'(DEF_POINTS);
      over_q       <= 1'b0;
      prev_over_q  <= 1'b0;
      reject_q     <= 1'b0;
      commit_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_people_q  <= sh_people_d;
      sh_secs_q    <= sh_secs_d;
      sh_corr_q    <= sh_corr_d;
      sh_miss_q    <= sh_miss_d;
      cfg_people_q <= cfg_people_d;
      cfg_secs_q   <= cfg_secs_d;
      cfg_corr_q   <= cfg_corr_d;
      cfg_miss_q   <= cfg_miss_d;
      over_q       <= over_d;
      prev_over_q  <= prev_over_d;
      reject_q     <= reject_d;
      commit_q     <= commit_d;
    end
  end

  assign cur_field     = state_q;
  assign is_set_over   = over_q;
  assign num_people    = cfg_people_q;
  assign count_seconds = cfg_secs_q;
  assign correct_point = cfg_corr_q;
  assign mistake_point = cfg_miss_q;
  assign reject        = reject_q;
  assign commit        = commit_q;

endmodule

// File: tb/tb_quiz_setup_ctrl.sv
// Directed plus randomized bench for quiz_setup_ctrl against a field-indexed reference model.
module tb_quiz_setup_ctrl;

  localparam int VW = 6;

  logic          clk = 1'b0;
  logic          rst, setting_en, enter_btn, back_btn;
  logic [VW-1:0] input_val;
  logic          is_set_over, reject, commit;
  logic [VW-1:0] num_people, count_seconds, correct_point, mistake_point;
  logic [2:0]    cur_field;

  int n_cmp = 0;
  int n_bad = 0;

  quiz_setup_ctrl dut (
    .clk(clk), .rst(rst), .setting_en(setting_en), .enter_btn(enter_btn),
    .back_btn(back_btn), .input_val(input_val), .is_set_over(is_set_over),
    .num_people(num_people), .count_seconds(count_seconds),
    .correct_point(correct_point), .mistake_point(mistake_point),
    .cur_field(cur_field), .reject(reject), .commit(commit)
  );

  always #5 clk = ~clk;

  // Reference model: field 0 = idle, 1..4 = entries, 5 = confirm; arrays indexed by field.
  int lo[5] = '{0, 2, 1, 1, 1};
  int hi[5] = '{0, 4, 60, 63, 63};
  int m_field;
  int m_sh[5];
  int m_cfg[5];
  bit m_over, m_prev_over, m_rej, m_com;
  bit m_en_q, m_bk_q, m_se_q;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit se, input bit en, input bit bk, input int v);
    bit ent, bck, entry;
    if (r) begin
      m_field = 0;
      m_cfg = '{0, 2, 20, 1, 1};
      m_sh = m_cfg;
      m_over = 0; m_prev_over = 0; m_rej = 0; m_com = 0;
      m_en_q = 0; m_bk_q = 0; m_se_q = 0;
      return;
    end
    ent = en && !m_en_q;
    bck = bk && !m_bk_q;
    entry = se && !m_se_q;
    m_en_q = en; m_bk_q = bk; m_se_q = se;
    m_rej = 0; m_com = 0;
    if (m_field == 0) begin
      if (entry) begin
        m_field = 1;
        m_sh = m_cfg;
        m_prev_over = m_over;
        m_over = 0;
      end
    end else if (!se) begin
      m_field = 0;
      m_over = m_prev_over;
    end else if (ent) begin
      if (m_field == 5) begin
        m_cfg = m_sh;
        m_com = 1;
        m_over = 1;
        m_field = 0;
      end else if (v >= lo[m_field] && v <= hi[m_field]) begin
        m_sh[m_field] = v;
        m_field++;
      end else begin
        m_rej = 1;
      end
    end else if (bck) begin
      if (m_field > 1) m_field--;
    end
  endtask

  task automatic cycle(input bit r, input bit se, input bit en, input bit bk, input int v);
    rst = r; setting_en = se; enter_btn = en; back_btn = bk; input_val = VW'(v);
    @(posedge clk);
    model_step(r, se, en, bk, v);
    @(negedge clk);
    chk("cur_field", int'(cur_field), m_field);
    chk("reject", int'(reject), int'(m_rej));
    chk("commit", int'(commit), int'(m_com));
    chk("is_set_over", int'(is_set_over), int'(m_over));
    chk("num_people", int'(num_people), m_cfg[1]);
    chk("count_seconds", int'(count_seconds), m_cfg[2]);
    chk("correct_point", int'(correct_point), m_cfg[3]);
    chk("mistake_point", int'(mistake_point), m_cfg[4]);
  endtask

  task automatic press(input int v);
    cycle(0, 1, 1, 0, v);
    cycle(0, 1, 0, 0, v);
  endtask

  task automatic go_back();
    cycle(0, 1, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
  endtask

  bit se_r;
  int v_r;

  initial begin
    // reset defaults
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_field", int'(cur_field), 0);
    chk("rst_people", int'(num_people), 2);
    chk("rst_secs", int'(count_seconds), 20);
    chk("rst_corr", int'(correct_point), 1);
    chk("rst_over", int'(is_set_over), 0);

    // full walk 3/30/5/2
    cycle(0, 1, 0, 0, 0);
    chk("t1_enter_field", int'(cur_field), 1);
    press(3); press(30); press(5); press(2);
    chk("t1_confirm_field", int'(cur_field), 5);
    cycle(0, 1, 1, 0, 0);
    chk("t1_commit", int'(commit), 1);
    cycle(0, 1, 0, 0, 0);
    chk("t1_commit_once", int'(commit), 0);
    chk("t1_people", int'(num_people), 3);
    chk("t1_secs", int'(count_seconds), 30);
    chk("t1_corr", int'(correct_point), 5);
    chk("t1_miss", int'(mistake_point), 2);
    chk("t1_over", int'(is_set_over), 1);
    repeat (3) cycle(0, 1, 0, 0, 0);
    chk("t1_no_reentry", int'(cur_field), 0);

    // abort keeps committed values
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    press(4);
    cycle(0, 0, 0, 0, 0);
    chk("t4_field", int'(cur_field), 0);
    chk("t4_people", int'(num_people), 3);
    chk("t4_over", int'(is_set_over), 1);

    // range boundaries and back step
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 1);
    chk("t2_rej_lo", int'(reject), 1);
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 1, 0, 5);
    chk("t2_rej_hi", int'(reject), 1);
    cycle(0, 1, 0, 0, 5);
    chk("t2_stay", int'(cur_field), 1);
    press(2);
    press(0); press(61);
    chk("t2_secs_stay", int'(cur_field), 2);
    press(60);
    chk("t2_secs_adv", int'(cur_field), 3);
    go_back();
    chk("t3_back", int'(cur_field), 2);
    press(10); press(7); press(9);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("t3_secs", int'(count_seconds), 10);
    chk("t2_people", int'(num_people), 2);

    // enter and back together, then held enter
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    press(3);
    cycle(0, 1, 1, 1, 15);
    chk("t5_both", int'(cur_field), 3);
    cycle(0, 1, 0, 0, 15);
    repeat (10) cycle(0, 1, 1, 0, 7);
    chk("t5_held", int'(cur_field), 4);
    cycle(0, 1, 0, 0, 7);

    // reset mid-setup
    cycle(1, 1, 0, 0, 0);
    chk("t6_field", int'(cur_field), 0);
    chk("t6_people", int'(num_people), 2);
    chk("t6_secs", int'(count_seconds), 20);
    chk("t6_miss", int'(mistake_point), 1);
    chk("t6_over", int'(is_set_over), 0);

    // randomized phase
    se_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!se_r) se_r = ($urandom_range(0, 3) == 0);
      else       se_r = ($urandom_range(0, 59) != 0);
      case ($urandom_range(0, 9))
        0: v_r = 0;
        1: v_r = 1;
        2: v_r = 2;
        3: v_r = 4;
        4: v_r = 5;
        5: v_r = 60;
        6: v_r = 61;
        7: v_r = 63;
        8: v_r = $urandom_range(1, 10);
        default: v_r = $urandom_range(0, 63);
      endcase
      cycle($urandom_range(0, 399) == 0, se_r, $urandom_range(0, 2) == 0,
            $urandom_range(0, 6) == 0, v_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quiz_setup_ctrl.md
Name: quiz_setup_ctrl

Overview:
Clocked, parametrised setup controller for the multichannel answering machine. It walks the host through player count, countdown seconds, correct-answer points and mistake points. Each entry is range-checked, and a back step is supported. Values are staged in shadow registers and committed atomically only on final confirm, so the game core always sees a consistent, valid configuration.

Parameters:
VAL_W, 6, width of input_val and all config outputs
MIN_PLAYERS, 2, minimum legal player count
MAX_PLAYERS, 4, maximum legal player count (≤ 2^VAL_W-1)
MAX_SECONDS, 60, maximum countdown seconds (min 1)
MAX_POINTS, 63, maximum correct/mistake points (min 1)
DEF_SECONDS, 20, reset value of count_seconds
DEF_POINTS, 1, reset value of correct_point and mistake_point

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
setting_en  in  1  level; high = setup mode requested
enter_btn  in  1  debounced level; rising edge = confirm current field
back_btn  in  1  debounced level; rising edge = return to previous field
input_val  in  VAL_W  value from switches
is_set_over  out  1  committed configuration valid, setup finished
num_people  out  VAL_W  committed player count
count_seconds  out  VAL_W  committed countdown
correct_point  out  VAL_W  committed points added
mistake_point  out  VAL_W  committed points deducted
cur_field  out  3  0=idle,1=people,2=seconds,3=correct,4=mistake,5=confirm
reject  out  1  one-cycle pulse: entry out of range
commit  out  1  one-cycle pulse: configuration committed

Behaviour:
- Reset (sync, rst high at posedge clk): state IDLE; num_people=MIN_PLAYERS, count_seconds=DEF_SECONDS, correct_point=mistake_point=DEF_POINTS; shadows equal these; is_set_over=0; reject=commit=0; button edge registers cleared. Reset mid-setup discards shadows.
- Edge detect: enter_e = enter_btn & ~enter_q, back_e likewise, with a one-flop history. Action is taken in the same cycle as the edge; outputs update on the next posedge. Held buttons act once.
- Both edges in one cycle: enter wins, back is ignored.
- FSM states: IDLE, S_PEOPLE, S_SECS, S_CORR, S_MISS, S_CONFIRM.
- IDLE: on setting_en=1, go to S_PEOPLE, copy committed values into shadows and clear is_set_over.
- S_PEOPLE..S_MISS on enter_e: if input_val is in range, write the shadow for that field and advance; otherwise pulse reject and stay.
- Ranges: people MIN_PLAYERS..MAX_PLAYERS; secs 1..MAX_SECONDS; corr and miss 1..MAX_POINTS. All comparisons are unsigned and VAL_W wide.
- back_e: move to the previous field; the shadow is kept. In S_PEOPLE, back_e is a no-op.
- S_CONFIRM on enter_e: copy all shadows to outputs in one cycle, pulse commit, set is_set_over=1, go to IDLE. On back_e: go to S_MISS.
- setting_en falls in any non-IDLE state: abort to IDLE. Outputs keep the previously committed values and is_set_over is restored to its pre-setup value (stored in one flop). Abort takes priority over enter_e and back_e in the same cycle.
- In IDLE, setting_en stays high after commit: no re-entry until setting_en falls and rises again (level-to-edge on entry).
- cur_field mirrors the state encoding directly.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package quiz_pkg: state encoding constants (IDLE..S_CONFIRM as 3-bit values), field index constants, and default/limit localparams shared with the game core.
- Sub-module btn_edge: one flop plus AND gate giving a rising-edge pulse. Instantiated twice (enter, back) and once for setting_en entry detection.

Test Plan:
1. Reset, then setting_en=1, enter with 3, 30, 5, 2, then enter → cur_field steps 1→2→3→4→5→0. commit pulses once. Outputs read 3/30/5/2 and is_set_over=1.
2. In S_PEOPLE, enter with input_val=1 and then 5 → reject pulses each time, cur_field stays 1. Then enter with 2 → advances. In S_SECS, enter with 0 and then 61 → reject, then 60 accepted.
3. Reach S_CORR, assert back_e → cur_field=2 with shadow seconds retained. Enter a new value of 10 and finish → count_seconds=10.
4. After a committed configuration (3/30/5/2), re-enter setup, enter people=4, then drop setting_en → IDLE, outputs still 3/30/5/2, is_set_over=1, commit not pulsed.
5. Assert enter_btn and back_btn on the same cycle in S_SECS with input_val=15 → advances to S_CORR. Hold enter_btn for 10 cycles → only one advance.
6. Assert rst mid-setup in S_MISS → next cycle: IDLE, outputs at defaults (2/20/1/1), is_set_over=0.
